abp_receiver_controller: RTL
============================

# abp_receiver_controller

Sequencing controller for the receiver side of the Alternating Bit Protocol. It sits beside the packet receiver and owns the expected sequence bit. It judges each completed packet as new, duplicate or dropped, and emits the 2-byte acknowledgement frame on an AXI-stream master. Accepted 64-bit payloads go to the consumer through a one-entry valid/ready holding slot.

## Interface
- ACK_MAGIC, 8'hAC: first byte of every ack frame
- CNT_W, 16: width of the saturating statistics counters
- aclk  in  1  sole clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  1 = accept new packets; 0 = finish the current ack, then hold in IDLE
- rx_done  in  1  one-cycle pulse from the packet receiver: packet complete
- rx_seq_bit  in  1  sequence bit of the completed packet, valid with rx_done
- rx_value  in  64  payload of the completed packet, valid with rx_done
- expected_bit  out  1  sequence bit currently expected, driven to the receiver
- rx_enable  out  1  receiver may accept a packet; = (state==IDLE) && enable
- m_axis_tvalid  out  1  ack stream valid
- m_axis_tready  in  1  ack stream ready
- m_axis_tdata  out  8  ack byte
- m_axis_tlast  out  1  last ack byte
- deliv_tvalid  out  1  delivered payload valid
- deliv_tready  in  1  consumer ready
- deliv_tdata  out  64  delivered payload
- dup_count  out  CNT_W  duplicate packets seen (re-acked, not delivered)
- drop_count  out  CNT_W  in-sequence packets dropped because the slot was full (not acked)
- overrun_count  out  CNT_W  rx_done pulses arriving while rx_enable==0

## Operation
- States: IDLE, EVAL, ACK0, ACK1.
- IDLE: on rx_done && enable, register rx_seq_bit and rx_value, then go to EVAL. Otherwise stay.
- EVAL (exactly one cycle). Slot free = !deliv_tvalid || deliv_tready (same-cycle drain counts as free).
  - rx_seq_bit==expected_bit and slot free: load deliv_tdata, set deliv_tvalid, toggle expected_bit, set ack bit = rx_seq_bit, go to ACK0.
  - rx_seq_bit==expected_bit and slot not free: drop_count++, no ack, expected_bit unchanged, go to IDLE.
  - rx_seq_bit!=expected_bit: dup_count++, no delivery, set ack bit = rx_seq_bit, go to ACK0.
- ACK0: tvalid=1, tdata=ACK_MAGIC, tlast=0. On tready, go to ACK1.
- ACK1: tvalid=1, tdata={7'b0, ack bit}, tlast=1. On tready, go to IDLE.
- Delivery slot: deliv_tvalid clears on a deliv_tvalid && deliv_tready handshake unless EVAL reloads it in the same cycle. Data and valid are held stable while waiting for ready.
- Counters saturate at all-ones and never wrap.
- overrun_count++ on any rx_done with rx_enable==0, including in EVAL/ACK0/ACK1 or with enable low. The pulse is otherwise ignored and no state changes.
- Deasserting enable mid-ack does not abort the frame. The controller completes ACK1, then idles.

## Timing
- Reset (async assert, sync to aclk on release) sets:
  - state=IDLE, expected_bit=0
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - deliv_tvalid=0, deliv_tdata=0
  - all counters=0
  - rx_enable=0 while reset is asserted.
- Reset mid-frame abandons the frame immediately. tvalid drops without tlast; this is acceptable by protocol because the sender retransmits.
- rx_done at edge T (in IDLE):
  - EVAL during cycle T+1.
  - expected_bit toggle and deliv_tvalid visible from T+2.
  - First ack byte valid from T+2.
- With tready held high, the ack frame occupies T+2 and T+3, and rx_enable returns high at T+4. The minimum packet-to-packet spacing is 4 cycles.
- Drop path: no ack, rx_enable high again at T+2.
- m_axis outputs depend only on state and registers. There is no combinational path from tready to tvalid/tdata.
- rx_enable is combinational from state and enable.

## Test plan
- After reset, rx_done with seq=0 and value=64'h0123_4567_89AB_CDEF, tready=1 -> deliv_tvalid=1 with that data at T+2. Ack bytes 8'hAC then 8'h00 with tlast on the second byte. expected_bit=1.
- Repeat seq=0 after the first ack (duplicate) -> dup_count=1, no new delivery, ack 8'hAC,8'h00, expected_bit stays 1.
- Hold deliv_tready=0, send seq=0 then seq=1 -> second packet: drop_count=1, no ack, expected_bit=1. Then raise deliv_tready for one cycle and resend seq=1 -> delivered, ack bit 1, expected_bit=0.
- m_axis_tready low for 5 cycles in ACK0 and ACK1 -> bytes and tlast held stable. rx_done pulses during the stall -> overrun_count increments per pulse; state is unaffected.
- deliv_tready=1 in the same cycle as an accepting EVAL with the slot full -> old word handshakes, new word loaded, deliv_tvalid stays 1, no drop.
- Assert aresetn low during ACK1 -> all outputs return to reset values immediately, expected_bit=0. Force dup_count to 16'hFFFF, then send a duplicate -> count stays 16'hFFFF.

Source files
------------

// File: rtl/abp_receiver_controller.sv
// Receiver-side Alternating Bit Protocol sequencer: classifies completed packets,
// emits the two-byte ack frame and hands accepted payloads to a one-entry slot.
module abp_receiver_controller #(
   parameter logic [7:0]  ACK_MAGIC = 8'hAC,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             enable,
   input  logic             rx_done,
   input  logic             rx_seq_bit,
   input  logic [63:0]      rx_value,
   output logic             expected_bit,
   output logic             rx_enable,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [7:0]       m_axis_tdata,
   output logic             m_axis_tlast,
   output logic             deliv_tvalid,
   input  logic             deliv_tready,
   output logic [63:0]      deliv_tdata,
   output logic [CNT_W-1:0] dup_count,
   output logic [CNT_W-1:0] drop_count,
   output logic [CNT_W-1:0] overrun_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EVAL,
      S_ACK0,
      S_ACK1
   } state_t;

   state_t           state_q, state_d;
   logic             exp_q, exp_d;
   logic             seq_q, seq_d;
   logic [63:0]      val_q, val_d;
   logic             ack_q, ack_d;
   logic             dv_q, dv_d;
   logic [63:0]      dd_q, dd_d;
   logic [CNT_W-1:0] dup_q, dup_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] ovr_q, ovr_d;

   logic             slot_free;
   logic             rx_en_w;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   // Gated by reset so the receiver is held off while reset is asserted.
   assign rx_en_w   = (state_q == S_IDLE) && enable && aresetn;
   assign rx_enable = rx_en_w;
   assign slot_free = !dv_q || deliv_tready;

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      seq_d   = seq_q;
      val_d   = val_q;
      ack_d   = ack_q;
      dv_d    = dv_q;
      dd_d    = dd_q;
      dup_d   = dup_q;
      drop_d  = drop_q;
      ovr_d   = ovr_q;

      if (dv_q && deliv_tready) begin
         dv_d = 1'b0;
      end

      if (rx_done && !rx_en_w) begin
         ovr_d = sat_inc(ovr_q);
      end

      case (state_q)
         S_IDLE: begin
            if (rx_done && enable) begin
               seq_d   = rx_seq_bit;
               val_d   = rx_value;
               state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            if (seq_q == exp_q) begin
               if (slot_free) begin
                  // Reload wins over the same-cycle drain of the previous word.
                  dv_d    = 1'b1;
                  dd_d    = val_q;
                  exp_d   = ~exp_q;
                  ack_d   = seq_q;
                  state_d = S_ACK0;
               end else begin
                  drop_d  = sat_inc(drop_q);
                  state_d = S_IDLE;
               end
            end else begin
               dup_d   = sat_inc(dup_q);
               ack_d   = seq_q;
               state_d = S_ACK0;
            end
         end
         S_ACK0: begin
            if (m_axis_tready) begin
               state_d = S_ACK1;
            end
         end
         S_ACK1: begin
            if (m_axis_tready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         exp_q   <= 1'b0;
         seq_q   <= 1'b0;
         val_q   <= '0;
         ack_q   <= 1'b0;
         dv_q    <= 1'b0;
         dd_q    <= '0;
         dup_q   <= '0;
         drop_q  <= '0;
         ovr_q   <= '0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         seq_q   <= seq_d;
         val_q   <= val_d;
         ack_q   <= ack_d;
         dv_q    <= dv_d;
         dd_q    <= dd_d;
         dup_q   <= dup_d;
         drop_q  <= drop_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      case (state_q)
         S_ACK0: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = ACK_MAGIC;
         end
         S_ACK1: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {7'b0, ack_q};
            m_axis_tlast  = 1'b1;
         end
         default: ;
      endcase
   end

   assign expected_bit  = exp_q;
   assign deliv_tvalid  = dv_q;
   assign deliv_tdata   = dd_q;
   assign dup_count     = dup_q;
   assign drop_count    = drop_q;
   assign overrun_count = ovr_q;

endmodule
